reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue for the out-of-order MIPS core. Dispatch allocates one
//  entry per instruction and receives its tag. Results arrive on the common data
//  bus (CDB). The oldest completed entry is presented for commit to the register
//  file or store path.
// PARAMETERS
//  DEPTH   32  number of entries; power of two; equals 2**TAG_W
//  TAG_W   5   entry tag / pointer width
//  REG_W   5   architectural register index width
//  DATA_W  32  result value width
// PORTS
//  clk              in   1       single clock, rising edge
//  rst_n            in   1       asynchronous active-low reset
//  allocate         in   1       request a new entry this cycle
//  dest_arch_reg    in   REG_W   destination arch register of the new entry
//  is_store         in   1       new entry is a store
//  alloc_tag        out  TAG_W   tag the next allocation receives (= tail pointer)
//  rob_full         out  1       all DEPTH entries occupied
//  cdb_valid        in   1       CDB broadcast valid
//  cdb_tag          in   TAG_W   entry the CDB result belongs to
//  cdb_val          in   DATA_W  CDB result value
//  commit_arch_reg  out  REG_W   head entry destination
//  commit_val       out  DATA_W  head entry value
//  commit_en        out  1       head entry valid and ready to retire
//  commit_is_store  out  1       head entry is a store
//  commit_ack       in   1       consumer retires the head this cycle
// BEHAVIOUR
//  - Entry state: valid, ready, dest, is_store, value. Circular buffer with head,
//    tail and a TAG_W+1-bit count.
//  - Reset: all entries are invalid. head=tail=count=0. alloc_tag=0, rob_full=0,
//    commit_en=0. commit_arch_reg, commit_val and commit_is_store are all 0.
//    Reset asserted mid-operation discards all entries.
//  - Allocate: if allocate && !rob_full, at the clock edge write entry[tail] with
//    valid=1, ready=0, dest=dest_arch_reg, is_store=is_store and value=0. Then
//    tail++ with wrap DEPTH-1->0. allocate while rob_full is ignored.
//  - alloc_tag and rob_full are combinational from registered state.
//    rob_full = (count==DEPTH).
//  - CDB: if cdb_valid && entry[cdb_tag].valid && !ready, set value=cdb_val and
//    ready=1 at the edge. A CDB to an invalid entry is ignored. A CDB to an entry
//    that is already ready is ignored (first write wins).
//  - Commit outputs are combinational from entry[head].
//    commit_en = entry[head].valid && entry[head].ready. When empty, commit_en=0.
//  - Retire: if commit_ack && commit_en, clear entry[head].valid and head++ with
//    wrap. commit_ack without commit_en is ignored. A held commit_ack retires one
//    entry per cycle while the head is ready.
//  - Simultaneous allocate and retire: both take effect and count is unchanged.
//    Full gating uses the pre-edge count, so there is no same-cycle slot reuse.
//  - A CDB write and an allocation to the same index in one cycle: the allocation
//    wins, because the entry was invalid before the edge.
//  - Latency: a CDB write makes commit_en visible the next cycle. Allocation to
//    commit takes at least 2 cycles.
// CONFIGURATION
//  ROB_CDB_BYPASS_EN defined:
//    - If the head is valid and not ready and cdb_valid && cdb_tag==head, then
//      commit_en=1 and commit_val=cdb_val in that same cycle.
//    - commit_ack then retires the entry directly.
//  ROB_CDB_BYPASS_EN undefined: no bypass; the behaviour above is exact.
// STRUCTURE
//  - rob_pkg holds:
//    - the DEPTH/TAG_W/REG_W/DATA_W localparams
//    - typedef rob_tag_t
//    - typedef struct rob_entry_t {valid, ready, is_store, dest, value}
//  - Single module with no sub-modules. The entry array and pointer logic live in
//    one always_ff with an async reset, plus one always_comb for outputs.
// TESTING
//  - Reset for 10 cycles -> alloc_tag=0, rob_full=0, commit_en=0.
//  - allocate=1, dest=1, is_store=1 for 5 cycles -> tags 0..4 allocated,
//    alloc_tag=5, commit_en=0.
//  - cdb_valid, tag=0, val=0x12153524 -> next cycle commit_en=1,
//    commit_arch_reg=1, commit_is_store=1, commit_val=0x12153524.
//  - Hold commit_ack for 5 cycles -> exactly one retire, head=1, then commit_en=0
//    because entry 1 is not ready.
//  - Allocate 32 entries with no commit -> rob_full=1. A 33rd allocate is ignored.
//    One retire clears full, and the tail wraps to 0.
//  - CDB to tags 2 then 1, ack held -> entries retire strictly in order 1,2.
//    A repeated CDB to a ready tag does not change its value.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizes and entry layout for the reorder buffer.
package rob_pkg;

  localparam int DEPTH  = 32;
  localparam int TAG_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              is_store;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue fed by dispatch and the CDB.
// Optional ROB_CDB_BYPASS_EN lets a CDB result to the head commit same cycle.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              allocate,
  input  logic [REG_W-1:0]  dest_arch_reg,
  input  logic              is_store,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic [REG_W-1:0]  commit_arch_reg,
  output logic [DATA_W-1:0] commit_val,
  output logic              commit_en,
  output logic              commit_is_store,
  input  logic              commit_ack
);

  rob_entry_t     ent_q [DEPTH];
  rob_tag_t       head_q;
  rob_tag_t       tail_q;
  logic [TAG_W:0] count_q;

  rob_entry_t head_e;
  rob_entry_t cdb_e;
  logic       do_alloc;
  logic       do_ret;
  logic       cdb_hit;

  assign head_e = ent_q[head_q];
  assign cdb_e  = ent_q[cdb_tag];

  always_comb begin
    rob_full        = (count_q == (TAG_W+1)'(DEPTH));
    alloc_tag       = tail_q;
    commit_arch_reg = head_e.dest;
    commit_is_store = head_e.is_store;
    commit_val      = head_e.value;
    commit_en       = head_e.valid && head_e.ready;
`ifdef ROB_CDB_BYPASS_EN
    if (head_e.valid && !head_e.ready &&
        cdb_valid && (cdb_tag == head_q)) begin
      commit_en  = 1'b1;
      commit_val = cdb_val;
    end
`endif
    do_alloc = allocate && !rob_full;
    do_ret   = commit_ack && commit_en;
    cdb_hit  = cdb_valid && cdb_e.valid && !cdb_e.ready;
  end

  // Later writes override earlier ones: retire beats CDB, allocate beats both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cdb_hit) begin
        ent_q[cdb_tag].ready <= 1'b1;
        ent_q[cdb_tag].value <= cdb_val;
      end
      if (do_ret) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      if (do_alloc) begin
        ent_q[tail_q] <= '{valid:    1'b1,
                           ready:    1'b0,
                           is_store: is_store,
                           dest:     dest_arch_reg,
                           value:    '0};
        tail_q        <= tail_q + 1'b1;
      end
      unique case ({do_alloc, do_ret})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a behavioural model and
// an in-order scoreboard of allocated tags.
module tb_reorder_buffer;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        allocate;
  logic [4:0]  dest_arch_reg;
  logic        is_store;
  logic [4:0]  alloc_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [4:0]  commit_arch_reg;
  logic [31:0] commit_val;
  logic        commit_en;
  logic        commit_is_store;
  logic        commit_ack;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .allocate(allocate), .dest_arch_reg(dest_arch_reg),
    .is_store(is_store), .alloc_tag(alloc_tag),
    .rob_full(rob_full), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .commit_arch_reg(commit_arch_reg), .commit_val(commit_val),
    .commit_en(commit_en), .commit_is_store(commit_is_store),
    .commit_ack(commit_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int npass = 0;
  int nret  = 0;

  logic        m_valid [D];
  logic        m_ready [D];
  logic        m_st    [D];
  logic [4:0]  m_dest  [D];
  logic [31:0] m_val   [D];
  int          m_head, m_tail, m_count;
  int          sb_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0; m_ready[i] = 0; m_st[i] = 0;
      m_dest[i] = '0; m_val[i] = '0;
    end
    m_head = 0; m_tail = 0; m_count = 0;
    sb_q.delete();
  endtask

  task automatic idle();
    allocate = 0; dest_arch_reg = '0; is_store = 0;
    cdb_valid = 0; cdb_tag = '0; cdb_val = '0;
    commit_ack = 0;
  endtask

  // One clock: check pre-edge commit, advance model, check post-edge.
  task automatic cycle();
    bit mce, full, doa, dor;
    int t;
    mce  = m_valid[m_head] && m_ready[m_head];
    full = (m_count == D);
    doa  = allocate && !full;
    dor  = commit_ack && mce;
    chk("commit_en", 32'(commit_en), 32'(mce));
    if (dor) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        t = sb_q.pop_front();
        chk("retire_tag", 32'(m_head), 32'(t));
        chk("commit_arch_reg", 32'(commit_arch_reg), 32'(m_dest[t]));
        chk("commit_is_store", 32'(commit_is_store), 32'(m_st[t]));
        chk("commit_val", commit_val, m_val[t]);
      end
      nret++;
    end
    t = int'(cdb_tag);
    if (cdb_valid && m_valid[t] && !m_ready[t]) begin
      m_ready[t] = 1; m_val[t] = cdb_val;
    end
    if (dor) begin
      m_valid[m_head] = 0;
      m_head = (m_head + 1) % D;
    end
    if (doa) begin
      m_valid[m_tail] = 1; m_ready[m_tail] = 0;
      m_st[m_tail] = is_store; m_dest[m_tail] = dest_arch_reg;
      m_val[m_tail] = '0;
      sb_q.push_back(m_tail);
      m_tail = (m_tail + 1) % D;
    end
    m_count = m_count + int'(doa) - int'(dor);
    @(posedge clk);
    #1;
    chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    chk("rob_full", 32'(rob_full), 32'(m_count == D));
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_commit_en", 32'(commit_en), 32'd0);
    chk("rst_arch", 32'(commit_arch_reg), 32'd0);
    chk("rst_val", commit_val, 32'd0);
    chk("rst_store", 32'(commit_is_store), 32'd0);
    rst_n = 1;

    // CDB to an invalid entry must be dropped
    cdb_valid = 1; cdb_tag = 5'd3; cdb_val = 32'hDEAD0003;
    cycle();
    idle();

    allocate = 1; dest_arch_reg = 5'd1; is_store = 1;
    repeat (5) cycle();
    idle();
    chk("alloc5_tag", 32'(alloc_tag), 32'd5);
    chk("alloc5_en", 32'(commit_en), 32'd0);

    cdb_valid = 1; cdb_tag = 5'd0; cdb_val = 32'h12153524;
    cycle();
    idle();
    chk("cdb_en", 32'(commit_en), 32'd1);
    chk("cdb_arch", 32'(commit_arch_reg), 32'd1);
    chk("cdb_store", 32'(commit_is_store), 32'd1);
    chk("cdb_val", commit_val, 32'h12153524);

    nret = 0;
    commit_ack = 1;
    repeat (5) cycle();
    idle();
    chk("ack_held_retires", 32'(nret), 32'd1);
    chk("ack_held_en", 32'(commit_en), 32'd0);

    // Fill from empty: 32 allocations wrap the tail to 0
    rst_n = 0;
    #2;
    model_reset();
    chk("midrst_en", 32'(commit_en), 32'd0);
    chk("midrst_tag", 32'(alloc_tag), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < D; i++) begin
      allocate = 1;
      dest_arch_reg = 5'(i);
      is_store = i[0];
      cycle();
    end
    chk("full_set", 32'(rob_full), 32'd1);
    chk("full_tag_wrap", 32'(alloc_tag), 32'd0);
    dest_arch_reg = 5'd31;
    cycle();
    chk("alloc33_tag", 32'(alloc_tag), 32'd0);

    // Retire with allocate high: full is judged pre-edge, no reuse
    cdb_valid = 1; cdb_tag = 5'd0; cdb_val = 32'hA0A0A0A0;
    allocate = 0;
    cycle();
    allocate = 1; cdb_valid = 0; commit_ack = 1;
    cycle();
    chk("unfull", 32'(rob_full), 32'd0);
    chk("unfull_tag", 32'(alloc_tag), 32'd0);
    idle();

    // Same-cycle allocate and CDB to the freed slot: allocation wins
    allocate = 1; dest_arch_reg = 5'd7;
    cdb_valid = 1; cdb_tag = 5'd0; cdb_val = 32'hBAD00000;
    cycle();
    idle();
    chk("refull", 32'(rob_full), 32'd1);
    chk("refull_tag", 32'(alloc_tag), 32'd1);

    cdb_valid = 1; cdb_tag = 5'd2; cdb_val = 32'h22222222;
    cycle();
    cdb_tag = 5'd3; cdb_val = 32'h33333333;
    cycle();
    chk("head1_not_ready", 32'(commit_en), 32'd0);
    cdb_tag = 5'd3; cdb_val = 32'h99999999;
    cycle();
    cdb_tag = 5'd1; cdb_val = 32'h11111111;
    commit_ack = 1;
    nret = 0;
    cycle();
    cdb_valid = 0;
    for (int i = 0; i < 8; i++) cycle();
    idle();
    chk("inorder_retires", 32'(nret), 32'd3);
    chk("drain_en", 32'(commit_en), 32'd0);
    chk("drain_tag", 32'(alloc_tag), 32'd1);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
